range_window_sched: RTL and testbench

- Session controller and scheduler for the min/max range datapath.
- Accepts a sample stream with valid and frames it into windows of a programmed length.
- Tracks min/max per window and publishes the range (max - min) through a single-entry valid/ready result register.
- Optional continuous re-arm; sticky protocol-error flags. Sits between the sample source and the result consumer.

---
 rtl/range_sched_pkg.sv | 18 +
 rtl/range_tracker.sv | 48 ++++
 rtl/range_window_sched.sv | 175 +++++++++++++++++
 tb/tb_range_window_sched.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/range_sched_pkg.sv
// Shared types and default widths for the min/max range window scheduler.
package range_sched_pkg;

    localparam int DATA_W_DEF = 10;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_ACCUM = 2'd2
    } state_e;

    // A session is in progress whenever the FSM is not idle.
    function automatic logic is_busy(input state_e st);
        return (st != ST_IDLE);
    endfunction

endpackage

// File: rtl/range_tracker.sv
// Running min/max holder for one window. The next-min/next-max outputs
// already include the incoming sample, so the completing cycle can form the
// range without waiting for the registers to update.
module range_tracker
    import range_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_seed,
    input  logic              i_update,
    input  logic [DATA_W-1:0] i_sample,
    output logic [DATA_W-1:0] o_next_min,
    output logic [DATA_W-1:0] o_next_max
);

    logic [DATA_W-1:0] r_min;
    logic [DATA_W-1:0] r_max;

    // Fold the incoming sample into the running extremes (or restart from it).
    always_comb begin
        o_next_min = r_min;
        o_next_max = r_max;
        if (i_seed) begin
            o_next_min = i_sample;
            o_next_max = i_sample;
        end else begin
            o_next_min = (i_sample < r_min) ? i_sample : r_min;
            o_next_max = (i_sample > r_max) ? i_sample : r_max;
        end
    end

    // Capture the folded extremes on every accepted sample.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_min <= {DATA_W{1'b0}};
            r_max <= {DATA_W{1'b0}};
        end else if (i_update) begin
            r_min <= o_next_min;
            r_max <= o_next_max;
        end else begin
            r_min <= r_min;
            r_max <= r_max;
        end
    end

endmodule

// File: rtl/range_window_sched.sv
// Session controller: frames the sample stream into windows, publishes the
// per-window range through a single-entry valid/ready register and keeps
// sticky protocol-error flags.
module range_window_sched
    import range_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic [CNT_W-1:0]  window_len,
    input  logic              start,
    input  logic              continuous,
    input  logic              abort,
    input  logic              clear_err,
    output logic [DATA_W-1:0] result_out,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              busy,
    output logic              err_overflow,
    output logic              err_cmd
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e            r_state;
    state_e            w_state_next;
    logic [CNT_W-1:0]  r_len;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_next;
    logic [DATA_W-1:0] r_result;
    logic              r_result_valid;
    logic              r_busy;
    logic              r_err_ovf;
    logic              r_err_cmd;
    logic [DATA_W-1:0] w_next_min;
    logic [DATA_W-1:0] w_next_max;
    logic [DATA_W-1:0] w_range;
    logic              w_in_session;
    logic              w_start_ok;
    logic              w_accept;
    logic              w_seed;
    logic              w_last;
    logic              w_cmd_err;
    logic              w_ovf_err;
    logic              w_load;
    logic              w_take;

    range_tracker #(.DATA_W(DATA_W)) u_tracker (
        .clock      (clock),
        .reset      (reset),
        .i_seed     (w_seed),
        .i_update   (w_accept),
        .i_sample   (sample_in),
        .o_next_min (w_next_min),
        .o_next_max (w_next_max)
    );

    // Per-cycle decode of sample acceptance, window completion and error events.
    always_comb begin
        w_in_session = is_busy(r_state);
        w_start_ok   = (r_state == ST_IDLE) && start && (window_len != {CNT_W{1'b0}});
        // abort outranks any sample arriving in the same cycle
        w_accept     = w_in_session && sample_valid && !abort;
        w_seed       = (r_state == ST_ARMED);
        w_count_next = w_seed ? CNT_ONE : (r_count + CNT_ONE);
        w_last       = w_accept && (w_count_next == r_len);
        w_range      = w_next_max - w_next_min;
        w_take       = r_result_valid && result_ready;
        w_ovf_err    = w_last && r_result_valid && !result_ready;
        w_load       = w_last && !w_ovf_err;
        w_cmd_err    = start && (((r_state == ST_IDLE) && (window_len == {CNT_W{1'b0}}))
                                 || (w_in_session && !abort));
    end

    // Next-state selection; abort beats completion and continuous re-arm.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_next = ST_ARMED;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ARMED, ST_ACCUM: begin
                if (abort) begin
                    w_state_next = ST_IDLE;
                end else if (w_last) begin
                    w_state_next = continuous ? ST_ARMED : ST_IDLE;
                end else if (w_accept) begin
                    w_state_next = ST_ACCUM;
                end else begin
                    w_state_next = r_state;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // FSM state, window length, sample counter and registered busy flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_len   <= {CNT_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= is_busy(w_state_next);
            if (w_start_ok) begin
                r_len <= window_len;
            end else begin
                r_len <= r_len;
            end
            if (w_accept) begin
                r_count <= w_count_next;
            end else begin
                r_count <= r_count;
            end
        end
    end

    // Single-entry result register: a completion loads it unless it is
    // still holding an untaken result with no handshake this cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_result       <= {DATA_W{1'b0}};
            r_result_valid <= 1'b0;
        end else if (w_load) begin
            r_result       <= w_range;
            r_result_valid <= 1'b1;
        end else if (w_take) begin
            r_result       <= r_result;
            r_result_valid <= 1'b0;
        end else begin
            r_result       <= r_result;
            r_result_valid <= r_result_valid;
        end
    end

    // Sticky error flags; a new event in the clearing cycle keeps the flag set.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_err_ovf <= 1'b0;
            r_err_cmd <= 1'b0;
        end else begin
            if (w_ovf_err) begin
                r_err_ovf <= 1'b1;
            end else if (clear_err) begin
                r_err_ovf <= 1'b0;
            end else begin
                r_err_ovf <= r_err_ovf;
            end
            if (w_cmd_err) begin
                r_err_cmd <= 1'b1;
            end else if (clear_err) begin
                r_err_cmd <= 1'b0;
            end else begin
                r_err_cmd <= r_err_cmd;
            end
        end
    end

    assign result_out   = r_result;
    assign result_valid = r_result_valid;
    assign busy         = r_busy;
    assign err_overflow = r_err_ovf;
    assign err_cmd      = r_err_cmd;

endmodule

// File: tb/tb_range_window_sched.sv
// Self-checking bench for range_window_sched: table-driven single windows,
// hand-written multi-cycle sequences and a result scoreboard.
module tb_range_window_sched;

    logic       clock = 1'b0;
    logic       reset;
    logic [9:0] sample_in;
    logic       sample_valid;
    logic [7:0] window_len;
    logic       start;
    logic       continuous;
    logic       abort;
    logic       clear_err;
    logic [9:0] result_out;
    logic       result_valid;
    logic       result_ready;
    logic       busy;
    logic       err_overflow;
    logic       err_cmd;

    int total = 0;
    int bad   = 0;
    logic [9:0] exp_q [$];

    typedef struct {
        logic [7:0]      len;
        int              n;
        int              gap;
        logic [0:7][9:0] s;
        logic [9:0]      exp;
    } vec_t;

    vec_t vecs [6];

    range_window_sched dut (
        .clock        (clock),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .window_len   (window_len),
        .start        (start),
        .continuous   (continuous),
        .abort        (abort),
        .clear_err    (clear_err),
        .result_out   (result_out),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy),
        .err_overflow (err_overflow),
        .err_cmd      (err_cmd)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // advance one clock; pulse-type inputs drop after each edge
    task automatic tick();
        @(posedge clock);
        #1;
        start        = 1'b0;
        sample_valid = 1'b0;
        abort        = 1'b0;
        clear_err    = 1'b0;
    endtask

    task automatic samp(input logic [9:0] v);
        sample_in    = v;
        sample_valid = 1'b1;
        tick();
    endtask

    task automatic do_start(input logic [7:0] len);
        window_len = len;
        start      = 1'b1;
        tick();
    endtask

    // scoreboard: every handshake must deliver the oldest expected result
    always @(negedge clock) begin
        if (!reset && result_valid && result_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected", {22'd0, result_out}, 32'hFFFF_FFFF);
            end else begin
                chk("sb_result", {22'd0, result_out}, {22'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{len: 8'd4, n: 4, gap: 0, s: '{10'd100, 10'd37, 10'd512, 10'd200, 10'd0, 10'd0, 10'd0, 10'd0}, exp: 10'd475};
        vecs[1] = '{len: 8'd1, n: 1, gap: 0, s: '{10'd5, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0}, exp: 10'd0};
        vecs[2] = '{len: 8'd3, n: 3, gap: 1, s: '{10'd7, 10'd7, 10'd9, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0}, exp: 10'd2};
        vecs[3] = '{len: 8'd8, n: 8, gap: 0, s: '{10'd1023, 10'd0, 10'd500, 10'd500, 10'd1, 10'd2, 10'd3, 10'd4}, exp: 10'd1023};
        vecs[4] = '{len: 8'd2, n: 2, gap: 1, s: '{10'd600, 10'd600, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0}, exp: 10'd0};
        vecs[5] = '{len: 8'd5, n: 5, gap: 0, s: '{10'd14, 10'd11, 10'd12, 10'd13, 10'd10, 10'd0, 10'd0, 10'd0}, exp: 10'd4};

        reset = 1'b0; sample_in = 10'd0; sample_valid = 1'b0; window_len = 8'd0;
        start = 1'b0; continuous = 1'b0; abort = 1'b0; clear_err = 1'b0; result_ready = 1'b1;
        #2 reset = 1'b1;
        #2;
        chk("rst_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_out", {22'd0, result_out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_errs", {30'd0, err_overflow, err_cmd}, 32'd0);
        @(posedge clock); #1 reset = 1'b0;
        tick();

        // single windows, non-continuous, consumer always ready
        for (int i = 0; i < 6; i++) begin
            do_start(vecs[i].len);
            chk("busy_armed", {31'd0, busy}, 32'd1);
            for (int k = 0; k < vecs[i].n; k++) begin
                if (k == vecs[i].n - 1) begin
                    exp_q.push_back(vecs[i].exp);
                    chk("valid_before_last", {31'd0, result_valid}, 32'd0);
                end
                samp(vecs[i].s[k]);
                if (vecs[i].gap != 0 && k != vecs[i].n - 1) tick();
            end
            chk("valid_lat1", {31'd0, result_valid}, 32'd1);
            chk("vec_out", {22'd0, result_out}, {22'd0, vecs[i].exp});
            chk("busy_done", {31'd0, busy}, 32'd0);
            tick();
            tick();
        end

        // continuous back-to-back windows, no gap sample
        continuous = 1'b1;
        do_start(8'd2);
        samp(10'd10);
        exp_q.push_back(10'd10);
        samp(10'd20);
        chk("cont_out1", {22'd0, result_out}, 32'd10);
        chk("cont_busy1", {31'd0, busy}, 32'd1);
        samp(10'd30);
        exp_q.push_back(10'd25);
        samp(10'd5);
        chk("cont_out2", {22'd0, result_out}, 32'd25);
        chk("cont_valid2", {31'd0, result_valid}, 32'd1);
        chk("cont_busy2", {31'd0, busy}, 32'd1);
        continuous = 1'b0; abort = 1'b1;
        tick();
        chk("cont_abort_busy", {31'd0, busy}, 32'd0);
        tick();

        // overflow while consumer stalls, then clear, then completion + handshake
        result_ready = 1'b0; continuous = 1'b1;
        do_start(8'd2);
        samp(10'd1);
        exp_q.push_back(10'd8);
        samp(10'd9);
        chk("ovf_first", {22'd0, result_out}, 32'd8);
        chk("ovf_none_yet", {31'd0, err_overflow}, 32'd0);
        samp(10'd4);
        samp(10'd4);
        chk("ovf_kept", {22'd0, result_out}, 32'd8);
        chk("ovf_valid", {31'd0, result_valid}, 32'd1);
        chk("ovf_flag", {31'd0, err_overflow}, 32'd1);
        clear_err = 1'b1;
        tick();
        chk("ovf_cleared", {31'd0, err_overflow}, 32'd0);
        samp(10'd2);
        result_ready = 1'b1;
        exp_q.push_back(10'd4);
        samp(10'd6);
        chk("ovf_swap_out", {22'd0, result_out}, 32'd4);
        chk("ovf_swap_noerr", {31'd0, err_overflow}, 32'd0);
        continuous = 1'b0; abort = 1'b1;
        tick();
        tick();

        // abort with concurrent sample, then a fresh session and command errors
        do_start(8'd5);
        samp(10'd3);
        samp(10'd900);
        abort = 1'b1;
        samp(10'd50);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("abort_noresult", {31'd0, result_valid}, 32'd0);
        do_start(8'd3);
        samp(10'd7);
        chk("cmd_before", {31'd0, err_cmd}, 32'd0);
        start = 1'b1; window_len = 8'd9;
        samp(10'd7);
        chk("cmd_busy_start", {31'd0, err_cmd}, 32'd1);
        exp_q.push_back(10'd2);
        samp(10'd9);
        chk("after_abort_out", {22'd0, result_out}, 32'd2);
        clear_err = 1'b1;
        tick();
        chk("cmd_cleared", {31'd0, err_cmd}, 32'd0);
        clear_err = 1'b1;
        do_start(8'd0);
        chk("cmd_len0_wins", {31'd0, err_cmd}, 32'd1);
        chk("len0_idle", {31'd0, busy}, 32'd0);
        clear_err = 1'b1;
        tick();
        tick();

        // asynchronous reset mid-session with a result pending
        result_ready = 1'b0;
        do_start(8'd2);
        samp(10'd3);
        samp(10'd10);
        chk("pend_out", {22'd0, result_out}, 32'd7);
        do_start(8'd4);
        samp(10'd1);
        samp(10'd2);
        start = 1'b1;
        tick();
        chk("pre_rst_cmd", {31'd0, err_cmd}, 32'd1);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", {31'd0, result_valid}, 32'd0);
        chk("arst_out", {22'd0, result_out}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_errs", {30'd0, err_overflow, err_cmd}, 32'd0);
        @(posedge clock); #1 reset = 1'b0;
        result_ready = 1'b1;
        tick();
        tick();
        chk("post_rst_valid", {31'd0, result_valid}, 32'd0);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
